// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants: native word width and forwarding-select encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/nmux_comb.sv
// Pure combinational N:1 select; out-of-range select codes yield ILLEGAL_VAL.
module nmux_comb #(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       N_IN        = 3,
  parameter logic [WIDTH-1:0]  ILLEGAL_VAL = '0,
  localparam int unsigned      SEL_W       = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      y
);

  always_comb begin
    y = ILLEGAL_VAL;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        y = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/operand_sel_stage.sv
// Registered N:1 operand select with valid/ready handshake and flush.
// Optional illegal-select error tracking is enabled by defining OPERAND_SEL_ERR_EN.
module operand_sel_stage
  import riscv_pkg::*;
#(
  parameter int unsigned       WIDTH       = XLEN,
  parameter int unsigned       N_IN        = 3,
  parameter logic [WIDTH-1:0]  ILLEGAL_VAL = '0,
  localparam int unsigned      SEL_W       = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef OPERAND_SEL_ERR_EN
  ,
  output logic                  sel_err,
  output logic [7:0]            err_cnt
`endif
);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             take;

  nmux_comb #(
    .WIDTH       (WIDTH),
    .N_IN        (N_IN),
    .ILLEGAL_VAL (ILLEGAL_VAL)
  ) u_nmux (
    .data_in (data_in),
    .sel     (sel),
    .y       (sel_val)
  );

  assign in_ready = !valid_q || out_ready;
  // A flushed cycle discards the incoming operand even though in_ready stays high.
  assign take     = in_valid && in_ready && !flush;

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (take) begin
      data_d  = sel_val;
      sel_d   = sel;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

`ifdef OPERAND_SEL_ERR_EN
  logic       sel_illegal;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  assign sel_illegal = (32'(sel) >= N_IN);

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (take && sel_illegal) begin
      err_d = 1'b1;
      if (cnt_q != 8'hff) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_err = err_q;
  assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_operand_sel_stage.sv
// Self-checking bench for operand_sel_stage: directed table, hand sequences, random vs model.
module tb_operand_sel_stage;
  import riscv_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N_IN  = 3;
  localparam int unsigned SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;
`ifdef OPERAND_SEL_ERR_EN
  logic                  sel_err;
  logic [7:0]            err_cnt;
`endif

  logic [WIDTH-1:0] words [N_IN];

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < N_IN; k++) data_in[k*WIDTH +: WIDTH] = words[k];
  end

  operand_sel_stage #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef OPERAND_SEL_ERR_EN
    ,
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a one-deep buffer holding at most one operand.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } item_t;
  item_t q[$];
  bit    m_err;
  int    m_cnt;

  function automatic void model_edge();
    item_t it;
    bit    rdy;
    if (rst) begin
      q.delete();
      m_err = 0;
      m_cnt = 0;
      return;
    end
    rdy = (q.size() == 0) || out_ready;
    if (flush) begin
      q.delete();
      return;
    end
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (in_valid && rdy) begin
      it.s = sel;
      it.d = (int'(sel) < N_IN) ? words[sel] : '0;
      q.push_back(it);
      if (int'(sel) >= N_IN) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endfunction

  task automatic check_model();
    check("model out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("model in_ready", 64'(in_ready), 64'((q.size() == 0) || out_ready));
    if (q.size() != 0) begin
      check("model out_data", 64'(out_data), 64'(q[0].d));
      check("model out_sel", 64'(out_sel), 64'(q[0].s));
    end
`ifdef OPERAND_SEL_ERR_EN
    check("model sel_err", 64'(sel_err), 64'(m_err));
    check("model err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic step(input bit chk);
    model_edge();
    @(posedge clk);
    #1;
    if (chk) check_model();
  endtask

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             out_ready;
    logic             flush;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ready;
  } vec_t;
  vec_t tbl[$];

  initial begin
    rst       = 1'b1;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    for (int k = 0; k < N_IN; k++) words[k] = 32'(k + 1);

    // Reset: two cycles asserted, then released.
    step(0);
    step(0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_sel", 64'(out_sel), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    step(1);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    // Directed table: sweep, flush-with-accept, flush-during-stall.
    tbl.push_back('{2'(FWD_REG), 1, 1, 0, 1, 32'd1, 1});
    tbl.push_back('{2'(FWD_MEM), 1, 1, 0, 1, 32'd2, 1});
    tbl.push_back('{2'(FWD_WB),  1, 1, 0, 1, 32'd3, 1});
    tbl.push_back('{2'd3,        1, 1, 0, 1, 32'd0, 1});
    tbl.push_back('{2'd2,        1, 1, 1, 0, 32'd0, 1});
    tbl.push_back('{2'd2,        0, 1, 0, 0, 32'd0, 1});
    tbl.push_back('{2'd1,        1, 1, 0, 1, 32'd2, 1});
    tbl.push_back('{2'd0,        1, 0, 1, 0, 32'd0, 1});
    tbl.push_back('{2'd0,        0, 0, 0, 0, 32'd0, 1});
    foreach (tbl[i]) begin
      sel       = tbl[i].sel;
      in_valid  = tbl[i].in_valid;
      out_ready = tbl[i].out_ready;
      flush     = tbl[i].flush;
      step(1);
      check($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ready));
      if (tbl[i].exp_valid)
        check($sformatf("tbl[%0d] out_data", i), 64'(out_data), 64'(tbl[i].exp_data));
    end
    flush = 1'b0;

    // Stall: hold 0x2 while upstream data changes, then release with a fresh operand.
    sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    step(1);
    check("stall load", 64'(out_data), 64'd2);
    sel = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      words[0] = $urandom;
      words[1] = $urandom;
      step(1);
      check("stall out_data", 64'(out_data), 64'd2);
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall in_ready", 64'(in_ready), 64'd0);
    end
    words[0]  = 32'h55;
    out_ready = 1'b1;
    #1;
    check("release in_ready", 64'(in_ready), 64'd1);
    step(1);
    check("release out_data", 64'(out_data), 64'h55);
    check("release out_valid", 64'(out_valid), 64'd1);

    // Back-to-back: eight operands in eight cycles, in order.
    for (int i = 0; i < 8; i++) begin
      words[0] = 32'(100 + i);
      sel      = 2'd0;
      step(1);
      check("b2b out_valid", 64'(out_valid), 64'd1);
      check("b2b out_data", 64'(out_data), 64'(100 + i));
    end
    in_valid = 1'b0;
    step(1);
    check("b2b drain", 64'(out_valid), 64'd0);

`ifdef OPERAND_SEL_ERR_EN
    rst = 1'b1;
    step(1);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3;
    step(1);
    step(1);
    sel = 2'd1;
    step(1);
    in_valid = 1'b0;
    step(1);
    check("err sel_err", 64'(sel_err), 64'd1);
    check("err err_cnt", 64'(err_cnt), 64'd2);
    rst = 1'b1;
    step(1);
    check("err rst sel_err", 64'(sel_err), 64'd0);
    check("err rst err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_IN; k++) words[k] = $urandom;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      step(1);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
